// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding and default frame geometry,
// used by both the SPI master and the existing SPI slave.
package spi_pkg;

    localparam int unsigned CLK_DIV_DEF = 25;
    localparam int unsigned DATA_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD,
        RELEASE
    } spi_state_e;

    // Counter width for a 0..n-1 range, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_if.sv
// Host-side handshake plus SPI pins of one SPI master channel.
interface spi_if
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) ();

    logic              start;
    logic [DATA_W-1:0] tx_data;
    logic              last;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rx_data;
    logic              SCK;
    logic              MOSI;
    logic              MISO;
    logic              SSEL;

    modport master (
        input  start, tx_data, last, MISO,
        output busy, done, rx_data, SCK, MOSI, SSEL
    );

    modport slave (
        output start, tx_data, last, MISO,
        input  busy, done, rx_data, SCK, MOSI, SSEL
    );

endinterface

// File: rtl/spi_clk_gen.sv
// Half-period counter for the SPI master: one tick every CLK_DIV cycles while
// enabled, tagged as SCK rise or fall by an internal phase bit.
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
    input  logic clk50M,
    input  logic rst,
    input  logic en,
    output logic rise,
    output logic fall,
    output logic tick
);

    localparam int unsigned CNT_W = cnt_w(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic             phase;

    assign tick = en && (cnt == CNT_MAX);
    assign rise = tick && !phase;
    assign fall = tick && phase;

    // Held at zero while disabled so every frame starts with a full half-period.
    always_ff @(posedge clk50M or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (!en) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (tick) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master: MSB-first frames of DATA_W bits, SCK half-period of CLK_DIV
// clocks, optional SSEL hold between frames for bursts.
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF
) (
    input logic   clk50M,
    input logic   rst,
    spi_if.master bus
);

    localparam int unsigned BIT_W = cnt_w(DATA_W);
    localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(DATA_W - 1);

    spi_state_e        state;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic [DATA_W-1:0] tx_next;
    logic [DATA_W-1:0] rx_next;
    logic [DATA_W-1:0] rx_data;
    logic [BIT_W-1:0]  bit_cnt;
    logic              last_frame;
    logic              sck;
    logic              mosi;
    logic              ssel;
    logic              busy;
    logic              done;
    logic              gen_en;
    logic              rise;
    logic              fall;
    logic              tick;

    // The generator also times the SSEL release tail after a last frame.
    assign gen_en = (state == SHIFT) || (state == RELEASE);

    spi_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_gen (
        .clk50M(clk50M),
        .rst   (rst),
        .en    (gen_en),
        .rise  (rise),
        .fall  (fall),
        .tick  (tick)
    );

    always_comb begin
        tx_next = tx_sr << 1;
        rx_next = (rx_sr << 1) | DATA_W'(bus.MISO);
    end

    always_ff @(posedge clk50M or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tx_sr      <= '0;
            rx_sr      <= '0;
            rx_data    <= '0;
            bit_cnt    <= '0;
            last_frame <= 1'b0;
            sck        <= 1'b0;
            mosi       <= 1'b0;
            ssel       <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE, HOLD: begin
                    if (bus.start) begin
                        tx_sr      <= bus.tx_data;
                        last_frame <= bus.last;
                        mosi       <= bus.tx_data[DATA_W-1];
                        ssel       <= 1'b0;
                        busy       <= 1'b1;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (rise) begin
                        sck   <= 1'b1;
                        rx_sr <= rx_next;
                    end else if (fall) begin
                        sck <= 1'b0;
                        if (bit_cnt == BIT_MAX) begin
                            // MOSI keeps the final bit; only the bookkeeping wraps.
                            bit_cnt <= '0;
                            done    <= 1'b1;
                            rx_data <= rx_sr;
                            busy    <= last_frame;
                            state   <= last_frame ? RELEASE : HOLD;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx_sr   <= tx_next;
                            mosi    <= tx_next[DATA_W-1];
                        end
                    end
                end
                RELEASE: begin
                    if (tick) begin
                        ssel  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.SCK     = sck;
    assign bus.MOSI    = mosi;
    assign bus.SSEL    = ssel;
    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.rx_data = rx_data;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: cycle-offset reference model compared every cycle,
// directed scenarios with literal expectations, and randomized frames.
module tb_spi_master;
    import spi_pkg::*;

    localparam int CD   = 2;
    localparam int DW   = 8;
    localparam int IW   = $clog2(DW);
    localparam int FT   = 2 * CD * DW;
    localparam int TCLK = 20;

    logic clk50M = 1'b0;
    logic rst    = 1'b1;

    spi_if #(.DATA_W(DW)) bus ();
    spi_if bus25 ();

    spi_master #(.CLK_DIV(CD), .DATA_W(DW)) u_dut (
        .clk50M(clk50M),
        .rst   (rst),
        .bus   (bus.master)
    );

    spi_master u_dut25 (
        .clk50M(clk50M),
        .rst   (rst),
        .bus   (bus25.master)
    );

    always #(TCLK / 2) clk50M = ~clk50M;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Slave: loopback, or shifts slave_word out MSB first, one bit per SCK rise.
    logic          loopback   = 1'b1;
    logic [DW-1:0] slave_word = '0;
    int            slave_cnt  = 0;

    always @(posedge bus.SCK or posedge bus.SSEL or posedge rst) begin
        if (rst || bus.SSEL) slave_cnt <= 0;
        else slave_cnt <= slave_cnt + 1;
    end

    assign bus.MISO   = loopback ? bus.MOSI : slave_word[IW'(DW - 1 - (slave_cnt % DW))];
    assign bus25.MISO = bus25.MOSI;

    // Reference model: outputs as a function of cycles since the accepting edge.
    int            cyc = 0;
    int            t;
    int            b;
    logic          m_active = 1'b0;
    int            m_e0 = 0;
    logic [DW-1:0] m_tx = '0;
    logic [DW-1:0] m_rxf = '0;
    logic          m_last = 1'b0;
    logic          m_ssel = 1'b1, m_sck = 1'b0, m_mosi = 1'b0, m_busy = 1'b0, m_done = 1'b0;
    logic [DW-1:0] m_rx = '0;

    always @(posedge clk50M or posedge rst) begin
        if (rst) begin
            m_active = 1'b0;
            m_ssel   = 1'b1;
            m_sck    = 1'b0;
            m_mosi   = 1'b0;
            m_busy   = 1'b0;
            m_done   = 1'b0;
            m_rx     = '0;
        end else begin
            cyc = cyc + 1;
            if (bus.start && !m_busy) begin
                m_active = 1'b1;
                m_e0     = cyc;
                m_tx     = bus.tx_data;
                m_last   = bus.last;
                m_rxf    = loopback ? bus.tx_data : slave_word;
            end
            m_done = 1'b0;
            m_sck  = 1'b0;
            if (m_active) begin
                t      = cyc - m_e0;
                m_ssel = 1'b0;
                if (t < FT) begin
                    m_sck  = ((t / CD) % 2) == 1;
                    b      = t / (2 * CD);
                    m_mosi = m_tx[IW'(DW - 1 - b)];
                    m_busy = 1'b1;
                end else begin
                    m_mosi = m_tx[0];
                    m_busy = m_last && (t < FT + CD);
                end
                if (t == FT) begin
                    m_done = 1'b1;
                    m_rx   = m_rxf;
                end
                if (m_last && t >= FT + CD) begin
                    m_ssel   = 1'b1;
                    m_active = 1'b0;
                end
            end
        end
    end

    always @(negedge clk50M) begin
        if (!rst) begin
            check("ssel", bus.SSEL, m_ssel);
            check("sck", bus.SCK, m_sck);
            check("mosi", bus.MOSI, m_mosi);
            check("busy", bus.busy, m_busy);
            check("done", bus.done, m_done);
            check("rx_data", bus.rx_data, m_rx);
        end
    end

    // Event monitors for the directed scenarios.
    int            done_cnt = 0, done_cyc = 0, e0_obs = 0, ssel_hi_cyc = 0, ssel_rise_cnt = 0;
    logic          prev_ssel = 1'b1;
    int            sck_rises = 0, rise_at_fall = 0, sel_rises = 0;
    logic [DW-1:0] mosi_cap = '0;
    int            done25_cnt = 0, done25_cyc = 0, sck25_n = 0;
    longint        sck25_t0 = 0, sck25_t1 = 0;

    always @(negedge clk50M) begin
        if (!rst) begin
            if (bus.done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (prev_ssel && !bus.SSEL) e0_obs = cyc;
            if (!prev_ssel && bus.SSEL) begin
                ssel_hi_cyc = cyc;
                ssel_rise_cnt++;
            end
            if (bus25.done === 1'b1) begin
                done25_cnt++;
                done25_cyc = cyc;
            end
        end
        prev_ssel = bus.SSEL;
    end

    always @(posedge bus.SCK) begin
        sck_rises++;
        mosi_cap = {mosi_cap[DW-2:0], bus.MOSI};
    end
    always @(negedge bus.SSEL) rise_at_fall = sck_rises;
    always @(posedge bus.SSEL) sel_rises = sck_rises - rise_at_fall;

    always @(posedge bus25.SCK) begin
        if (sck25_n == 0) sck25_t0 = $time;
        if (sck25_n == 1) sck25_t1 = $time;
        sck25_n++;
    end

    int last_e0 = 0;

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk50M);
        while (bus.busy !== 1'b0 && n < 200) begin
            @(negedge clk50M);
            n++;
        end
        if (bus.busy !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, expected 0", bus.busy, n);
        end
    endtask

    task automatic send(input logic [DW-1:0] tx, input logic lst, input logic lb,
                        input logic [DW-1:0] sw);
        wait_idle();
        loopback    = lb;
        slave_word  = sw;
        bus.tx_data = tx;
        bus.last    = lst;
        bus.start   = 1'b1;
        last_e0     = cyc + 1;
        @(negedge clk50M);
        bus.start   = 1'b0;
        bus.tx_data = DW'($urandom);
        bus.last    = 1'($urandom);
    endtask

    initial begin
        #(TCLK * 100000);
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        int d0, sr0, k0, n, e0_25;
        bus.start     = 1'b0;
        bus.tx_data   = '0;
        bus.last      = 1'b0;
        bus25.start   = 1'b0;
        bus25.tx_data = '0;
        bus25.last    = 1'b0;

        repeat (2) @(negedge clk50M);
        check("rst_ssel", bus.SSEL, 1'b1);
        check("rst_sck", bus.SCK, 1'b0);
        check("rst_mosi", bus.MOSI, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_rx", bus.rx_data, 8'h00);
        #2 rst = 1'b0;

        // Single byte, loopback.
        send(8'hA5, 1'b1, 1'b1, 8'h00);
        wait_idle();
        @(negedge clk50M);
        #1;
        check("s1_ssel_fall", e0_obs, last_e0);
        check("s1_done_cyc", done_cyc, last_e0 + 32);
        check("s1_ssel_rise", ssel_hi_cyc, last_e0 + 34);
        check("s1_mosi_bits", mosi_cap, 8'hA5);
        check("s1_rx", bus.rx_data, 8'hA5);

        // External slave data.
        send(8'hFF, 1'b1, 1'b0, 8'h3C);
        wait_idle();
        @(negedge clk50M);
        #1;
        check("s2_rx", bus.rx_data, 8'h3C);
        check("s2_rises", sel_rises, 8);

        // Burst of two bytes under one SSEL.
        d0  = done_cnt;
        sr0 = ssel_rise_cnt;
        send(8'h12, 1'b0, 1'b1, 8'h00);
        send(8'h34, 1'b1, 1'b1, 8'h00);
        wait_idle();
        @(negedge clk50M);
        #1;
        check("s3_dones", done_cnt - d0, 2);
        check("s3_ssel_rises", ssel_rise_cnt - sr0, 1);
        check("s3_sck_rises", sel_rises, 16);
        check("s3_rx", bus.rx_data, 8'h34);

        // Start pulses while busy are ignored.
        d0 = done_cnt;
        send(8'hC3, 1'b1, 1'b1, 8'h00);
        repeat (5) @(negedge clk50M);
        bus.start   = 1'b1;
        bus.tx_data = 8'h00;
        @(negedge clk50M);
        bus.start = 1'b0;
        repeat (10) @(negedge clk50M);
        bus.start = 1'b1;
        @(negedge clk50M);
        bus.start = 1'b0;
        wait_idle();
        @(negedge clk50M);
        #1;
        check("s4_dones", done_cnt - d0, 1);
        check("s4_rx", bus.rx_data, 8'hC3);

        // Reset after the 4th SCK rise.
        d0 = done_cnt;
        k0 = sck_rises;
        send(8'h5A, 1'b1, 1'b0, 8'h96);
        n = 0;
        while (sck_rises - k0 < 4 && n < 100) begin
            @(negedge clk50M);
            n++;
        end
        check("s5_reach_rise4", sck_rises - k0, 4);
        #2 rst = 1'b1;
        #1;
        check("s5_ssel", bus.SSEL, 1'b1);
        check("s5_sck", bus.SCK, 1'b0);
        check("s5_busy", bus.busy, 1'b0);
        check("s5_rx", bus.rx_data, 8'h00);
        check("s5_done", bus.done, 1'b0);
        check("s5_mosi", bus.MOSI, 1'b0);
        repeat (3) @(negedge clk50M);
        #2 rst = 1'b0;
        repeat (4) @(negedge clk50M);
        check("s5_no_done", done_cnt - d0, 0);
        send(8'h69, 1'b1, 1'b0, 8'hE1);
        wait_idle();
        @(negedge clk50M);
        #1;
        check("s5_next_rx", bus.rx_data, 8'hE1);

        // Randomized frames, bursts and ignored starts.
        repeat (40) begin
            repeat ($urandom_range(0, 3)) @(negedge clk50M);
            send(DW'($urandom), 1'($urandom), 1'($urandom), DW'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 12)) @(negedge clk50M);
                if (bus.busy === 1'b1) begin
                    bus.start   = 1'b1;
                    bus.tx_data = DW'($urandom);
                    bus.last    = 1'($urandom);
                    @(negedge clk50M);
                    bus.start = 1'b0;
                end
            end
        end
        send(DW'($urandom), 1'b1, 1'b1, 8'h00);
        wait_idle();

        // Default divider instance.
        @(negedge clk50M);
        e0_25         = cyc + 1;
        bus25.tx_data = 8'h6D;
        bus25.last    = 1'b1;
        bus25.start   = 1'b1;
        @(negedge clk50M);
        bus25.start   = 1'b0;
        bus25.tx_data = 8'($urandom);
        n = 0;
        while (bus25.busy !== 1'b0 && n < 600) begin
            @(negedge clk50M);
            n++;
        end
        check("s6_idle", bus25.busy, 1'b0);
        @(negedge clk50M);
        #1;
        check("s6_sck_period", 32'(sck25_t1 - sck25_t0), 1000);
        check("s6_done_cyc", done25_cyc, e0_25 + 400);
        check("s6_dones", done25_cnt, 1);
        check("s6_rises", sck25_n, 8);
        check("s6_rx", bus25.rx_data, 8'h6D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
